// File: rtl/twiddle_rot8.sv
// ============================================================================
// twiddle_rot8 : stage-3 twiddle rotator of the 8-point DIF FFT datapath
// Revision     : 1.0
// ============================================================================
`default_nettype none

module div_sqrt_2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    logic signed [W-1:0] x_s;
    logic        [W-1:0] part_a_d, part_b_d;
    logic        [W-1:0] part_a_q, part_b_q, y_q;

    assign x_s = x_i;

    // Two-stage shift-add: 1/2 + 1/8 + 1/16 + 1/64 + 1/256, all floor shifts.
    always_comb begin
        part_a_d = (x_s >>> 1) + (x_s >>> 3);
        part_b_d = (x_s >>> 4) + (x_s >>> 6) + (x_s >>> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            part_a_q <= '0;
            part_b_q <= '0;
            y_q      <= '0;
        end else begin
            part_a_q <= part_a_d;
            part_b_q <= part_b_d;
            y_q      <= part_a_q + part_b_q;
        end
    end

    assign y_o = y_q;
endmodule

module twiddle_rot8 #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_first,
    input  logic [2**N-1:0] in_re,
    input  logic [2**N-1:0] in_im,
    output logic            out_valid,
    output logic            out_last,
    output logic            out_resync,
    output logic [2**N-1:0] out_re,
    output logic [2**N-1:0] out_im
);
    localparam int       W      = 2**N;
    localparam int       STAGES = 3;
    localparam logic [2:0] POS_W1 = 3'd5;
    localparam logic [2:0] POS_W2 = 3'd6;
    localparam logic [2:0] POS_W3 = 3'd7;

    logic [2:0]        pos_q, pos_d, p;
    logic [STAGES-1:0] vld_q, last_q, rsy_q, rot_q;
    logic              last_d, rsy_d, rot_d;
    logic [W-1:0]      pass_re_d, pass_im_d, pre_re_d, pre_im_d;
    logic [W-1:0]      pass_re_q [STAGES];
    logic [W-1:0]      pass_im_q [STAGES];
    logic [W-1:0]      pre_re_q, pre_im_q;
    logic [W-1:0]      div_re, div_im;

    always_comb begin
        p         = in_first ? 3'd0 : pos_q;
        pos_d     = in_valid ? p + 3'd1 : pos_q;
        last_d    = in_valid && (p == POS_W3);
        rsy_d     = in_valid && in_first && (pos_q != 3'd0);
        rot_d     = in_valid && ((p == POS_W1) || (p == POS_W3));
        pass_re_d = in_re;
        pass_im_d = in_im;
        pre_re_d  = '0;
        pre_im_d  = '0;
        case (p)
            POS_W1: begin
                pre_re_d = in_re + in_im;
                pre_im_d = in_im - in_re;
            end
            POS_W2: begin
                pass_re_d = in_im;
                pass_im_d = -in_re;
            end
            POS_W3: begin
                pre_re_d = in_im - in_re;
                pre_im_d = -in_re - in_im;
            end
            default: ;
        endcase
    end

    // Pass-through values ride a 3-deep delay line to match the scaler path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q    <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            rsy_q    <= '0;
            rot_q    <= '0;
            pre_re_q <= '0;
            pre_im_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pass_re_q[i] <= '0;
                pass_im_q[i] <= '0;
            end
        end else begin
            pos_q        <= pos_d;
            vld_q        <= {vld_q[STAGES-2:0], in_valid};
            last_q       <= {last_q[STAGES-2:0], last_d};
            rsy_q        <= {rsy_q[STAGES-2:0], rsy_d};
            rot_q        <= {rot_q[STAGES-2:0], rot_d};
            pre_re_q     <= pre_re_d;
            pre_im_q     <= pre_im_d;
            pass_re_q[0] <= pass_re_d;
            pass_im_q[0] <= pass_im_d;
            for (int i = 1; i < STAGES; i++) begin
                pass_re_q[i] <= pass_re_q[i-1];
                pass_im_q[i] <= pass_im_q[i-1];
            end
        end
    end

    div_sqrt_2 #(.W(W)) u_div_re (
        .clk (clk),
        .rst (rst),
        .x_i (pre_re_q),
        .y_o (div_re)
    );

    div_sqrt_2 #(.W(W)) u_div_im (
        .clk (clk),
        .rst (rst),
        .x_i (pre_im_q),
        .y_o (div_im)
    );

    always_comb begin
        out_valid  = vld_q[STAGES-1];
        out_last   = vld_q[STAGES-1] & last_q[STAGES-1];
        out_resync = vld_q[STAGES-1] & rsy_q[STAGES-1];
        out_re     = '0;
        out_im     = '0;
        if (vld_q[STAGES-1]) begin
            out_re = rot_q[STAGES-1] ? div_re : pass_re_q[STAGES-1];
            out_im = rot_q[STAGES-1] ? div_im : pass_im_q[STAGES-1];
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_twiddle_rot8.sv
// ============================================================================
// tb_twiddle_rot8 : table-driven, scoreboarded bench for twiddle_rot8
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_twiddle_rot8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        out_valid, out_last, out_resync;
    logic [15:0] out_re, out_im;

    twiddle_rot8 #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_resync (out_resync),
        .out_re     (out_re),
        .out_im     (out_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
        logic        rs;
        string       name;
    } exp_t;

    typedef struct {
        logic        f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ere;
        logic [15:0] eim;
        logic        el;
        logic        er;
    } vec_t;

    exp_t       q[$];
    vec_t       tbl[8];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic       chk_en = 1'b0;
    logic       finish_req = 1'b0;
    logic [2:0] tb_pos = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (out_valid !== 1'b1 || out_re !== e.re || out_im !== e.im ||
                    out_last !== e.last || out_resync !== e.rs) begin
                    fails++;
                    $display("FAIL %s @%0d: got v=%b re=%0d im=%0d last=%b rs=%b, want v=1 re=%0d im=%0d last=%b rs=%b",
                             e.name, cyc, out_valid, $signed(out_re), $signed(out_im), out_last, out_resync,
                             $signed(e.re), $signed(e.im), e.last, e.rs);
                end
            end else if (out_valid !== 1'b0 || out_re !== 16'd0 || out_im !== 16'd0 ||
                         out_last !== 1'b0 || out_resync !== 1'b0) begin
                fails++;
                $display("FAIL idle @%0d: got v=%b re=%0d im=%0d last=%b rs=%b, want all zero",
                         cyc, out_valid, $signed(out_re), $signed(out_im), out_last, out_resync);
            end
        end
        if (finish_req) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: got no output, want re=%0d im=%0d", e.name, $signed(e.re), $signed(e.im));
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        if (cyc > 20000) begin
            $display("FAIL watchdog: got cycle %0d, want finish before 20000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    function automatic logic [15:0] s_fn(input logic [15:0] t);
        int x, r;
        x = int'($signed(t));
        r = (x >>> 1) + (x >>> 3) + (x >>> 4) + (x >>> 6) + (x >>> 8);
        return r[15:0];
    endfunction

    task automatic send(input logic f, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ere, input logic [15:0] eim,
                        input logic el, input logic er, input string nm);
        logic [2:0] p;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_first = f;
        in_re    = a;
        in_im    = b;
        q.push_back('{cyc + 3, ere, eim, el, er, nm});
        p      = f ? 3'd0 : tb_pos;
        tb_pos = p + 3'd1;
    endtask

    task automatic send_model(input logic f, input logic [15:0] a, input logic [15:0] b, input string nm);
        logic [2:0]  p;
        logic [15:0] ere, eim;
        p   = f ? 3'd0 : tb_pos;
        ere = a;
        eim = b;
        case (p)
            3'd5: begin ere = s_fn(a + b); eim = s_fn(b - a); end
            3'd6: begin ere = b;           eim = -a;          end
            3'd7: begin ere = s_fn(b - a); eim = s_fn(-a - b); end
            default: ;
        endcase
        send(f, a, b, ere, eim, p == 3'd7, f && (tb_pos != 3'd0), nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_first = 1'b0;
            in_re    = '0;
            in_im    = '0;
        end
    endtask

    task automatic rand_sample(output logic [15:0] a, output logic [15:0] b);
        a = 16'($urandom_range(0, 4000)) - 16'd2000;
        b = 16'($urandom_range(0, 4000)) - 16'd2000;
    endtask

    initial begin
        logic [15:0] a, b;

        for (int i = 0; i < 5; i++)
            tbl[i] = '{(i == 0), 16'(i * 100), 16'(-i * 100), 16'(i * 100), 16'(-i * 100), 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'd1000, 16'd0,     16'd705,     16'(-708), 1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'd300,  16'(-200), 16'(-200),   16'(-300), 1'b0, 1'b0};
        tbl[7] = '{1'b0, 16'd1000, 16'd0,     16'(-708),   16'(-708), 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++)
            send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].ere, tbl[i].eim, tbl[i].el, tbl[i].er,
                 $sformatf("table[%0d]", i));
        idle(2);

        // Two frames with random gaps; the second relies on the 7->0 wrap.
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 8; i++) begin
                rand_sample(a, b);
                send_model(fr == 0 && i == 0, a, b, $sformatf("gap f%0d p%0d", fr, i));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end

        // Back-to-back frame with a redundant in_first at pos 0.
        for (int i = 0; i < 8; i++) begin
            rand_sample(a, b);
            send_model(i == 0, a, b, $sformatf("b2b p%0d", i));
        end

        // Resync at pos 3.
        for (int i = 0; i < 3; i++) begin
            rand_sample(a, b);
            send_model(i == 0, a, b, $sformatf("pre_rsy p%0d", i));
        end
        send(1'b1, 16'd111, 16'd222, 16'd111, 16'd222, 1'b0, 1'b1, "resync");
        for (int i = 1; i < 8; i++) begin
            rand_sample(a, b);
            send_model(1'b0, a, b, $sformatf("post_rsy p%0d", i));
        end

        // Mid-frame reset discards in-flight samples.
        for (int i = 0; i < 3; i++) begin
            rand_sample(a, b);
            send_model(i == 0, a, b, "discard");
        end
        @(negedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        q.delete();
        tb_pos   = 3'd0;
        @(negedge clk); #1;
        rst = 1'b0;
        idle(3);
        send(1'b0, 16'd1234, 16'(-567), 16'd1234, 16'(-567), 1'b0, 1'b0, "post_rst p0");
        for (int i = 1; i < 8; i++) begin
            rand_sample(a, b);
            send_model(1'b0, a, b, $sformatf("post_rst p%0d", i));
        end

        idle(6);
        finish_req = 1'b1;
    end
endmodule

`default_nettype wire
